// File: rtl/preg_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : preg_alloc_ctrl
// Purpose  : Physical-register allocation sequencer. Sits between the 2-wide
//            rename stage, the 2-wide commit stage and a single-port
//            free_list.
//            - Prefetches pregs into a small buffer so rename can take two
//              per cycle.
//            - Queues commit frees and drains them one per cycle.
//            - Backs off allocation while the free_list is exhausted.
// Options  : PREG_FREE_BYPASS_EN - while exhausted, the free queue head is
//            pushed straight into the prefetch buffer instead of the
//            free_list.
// Revision : 1.0 - initial release
// ============================================================================
module preg_alloc_ctrl #(
    parameter  int PHYS_REGS = 64,
    parameter  int PF_DEPTH  = 4,
    parameter  int FQ_DEPTH  = 8,
    localparam int PW        = $clog2(PHYS_REGS),
    localparam int PCW       = $clog2(PF_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     rn_req,
    output logic [1:0]     rn_avail,
    output logic [PW-1:0]  rn_phys0,
    output logic [PW-1:0]  rn_phys1,
    input  logic [1:0]     cm_free_en,
    input  logic [PW-1:0]  cm_free_phys0,
    input  logic [PW-1:0]  cm_free_phys1,
    output logic           cm_free_ready,
    output logic           fl_alloc_en,
    input  logic [PW-1:0]  fl_alloc_phys,
    input  logic           fl_alloc_valid,
    output logic           fl_free_en,
    output logic [PW-1:0]  fl_free_phys,
    output logic [PCW-1:0] pf_count,
    output logic           fl_exhausted
);

    localparam int PPW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int FPW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int FCW = $clog2(FQ_DEPTH + 1);
    localparam logic [PCW-1:0] C_PF_FULL  = PCW'(PF_DEPTH);
    localparam logic [FCW-1:0] C_FQ_FULL  = FCW'(FQ_DEPTH);
    localparam logic [FCW-1:0] C_FQ_SPARE = FCW'(FQ_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXH  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [PW-1:0]  r_pf_mem [PF_DEPTH];
    logic [PPW-1:0] r_pf_head, r_pf_tail;
    logic [PCW-1:0] r_pf_cnt;
    logic [PW-1:0]  r_fq_mem [FQ_DEPTH];
    logic [FPW-1:0] r_fq_head, r_fq_tail;
    logic [FCW-1:0] r_fq_cnt;

    logic [PPW-1:0] w_pf_head1, w_pf_head2;
    logic [FPW-1:0] w_fq_tail1, w_fq_tail2;
    logic [1:0]     w_avail_n, w_req_n, w_pop_n, w_fq_push_n;
    logic           w_req_ok, w_pf_not_full, w_fq_empty, w_bypass;
    logic           w_alloc_push, w_pf_push, w_alloc_fail;
    logic [PW-1:0]  w_pf_wdata;
    logic [PCW-1:0] w_pf_cnt_nxt;

    function automatic logic [PPW-1:0] f_pf_inc(input logic [PPW-1:0] p);
        return (p == PPW'(PF_DEPTH - 1)) ? '0 : p + PPW'(1);
    endfunction

    function automatic logic [FPW-1:0] f_fq_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FQ_DEPTH - 1)) ? '0 : p + FPW'(1);
    endfunction

    assign w_pf_head1    = f_pf_inc(r_pf_head);
    assign w_pf_head2    = f_pf_inc(w_pf_head1);
    assign w_fq_tail1    = f_fq_inc(r_fq_tail);
    assign w_fq_tail2    = f_fq_inc(w_fq_tail1);
    assign w_pf_not_full = (r_pf_cnt < C_PF_FULL);
    assign w_fq_empty    = (r_fq_cnt == '0);

    // Rename side: availability is hidden during the initial fill.
    assign rn_avail  = (r_state == ST_FILL) ? 2'b00
                     : {(r_pf_cnt >= PCW'(2)), (r_pf_cnt != '0)};
    assign w_avail_n = {1'b0, rn_avail[1]} + {1'b0, rn_avail[0]};
    assign w_req_n   = {1'b0, rn_req[1]} + {1'b0, rn_req[0]};
    assign w_req_ok  = (w_req_n <= w_avail_n);
    assign w_pop_n   = w_req_ok ? w_req_n : 2'd0;
    assign rn_phys0  = rn_req[0] ? r_pf_mem[r_pf_head] : '0;
    assign rn_phys1  = rn_req[1] ? (rn_req[0] ? r_pf_mem[w_pf_head1] : r_pf_mem[r_pf_head]) : '0;

    // Allocation is requested from the registered count only, so the
    // free_list never sees a combinational path from rn_req.
    assign fl_alloc_en  = !reset && (r_state != ST_EXH) && w_pf_not_full;
    assign w_alloc_push = fl_alloc_en && fl_alloc_valid;
    assign w_alloc_fail = fl_alloc_en && !fl_alloc_valid;

`ifdef PREG_FREE_BYPASS_EN
    assign w_bypass = (r_state == ST_EXH) && !w_fq_empty && w_pf_not_full;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pf_push     = w_alloc_push || w_bypass;
    assign w_pf_wdata    = w_bypass ? r_fq_mem[r_fq_head] : fl_alloc_phys;
    assign w_pf_cnt_nxt  = r_pf_cnt + PCW'(w_pf_push) - PCW'(w_pop_n);

    assign fl_free_en    = !w_fq_empty && !w_bypass;
    assign fl_free_phys  = fl_free_en ? r_fq_mem[r_fq_head] : '0;
    assign w_fq_push_n   = {1'b0, cm_free_en[1]} + {1'b0, cm_free_en[0]};
    assign cm_free_ready = (r_fq_cnt <= C_FQ_SPARE);
    assign pf_count      = r_pf_cnt;
    assign fl_exhausted  = (r_state == ST_EXH);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FILL;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: fill up, run, or back off until a preg is returned.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_alloc_fail)                    w_state_nxt = ST_EXH;
                else if (w_pf_cnt_nxt == C_PF_FULL)  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_alloc_fail)                    w_state_nxt = ST_EXH;
            end
            ST_EXH: begin
                if (fl_free_en || w_bypass)          w_state_nxt = ST_RUN;
            end
            default:                                 w_state_nxt = ST_FILL;
        endcase
    end

    // Prefetch buffer: one push, up to two pops per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pf_head <= '0;
            r_pf_tail <= '0;
            r_pf_cnt  <= '0;
            for (int i = 0; i < PF_DEPTH; i++) r_pf_mem[i] <= '0;
        end else begin
            if (w_pf_push) begin
                r_pf_mem[r_pf_tail] <= w_pf_wdata;
                r_pf_tail           <= f_pf_inc(r_pf_tail);
            end
            if (w_pop_n == 2'd1)      r_pf_head <= w_pf_head1;
            else if (w_pop_n == 2'd2) r_pf_head <= w_pf_head2;
            r_pf_cnt <= w_pf_cnt_nxt;
        end
    end

    // Free queue: up to two enqueues (lane0 first), one dequeue per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fq_head <= '0;
            r_fq_tail <= '0;
            r_fq_cnt  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) r_fq_mem[i] <= '0;
        end else begin
            case (cm_free_en)
                2'b01: begin
                    r_fq_mem[r_fq_tail] <= cm_free_phys0;
                    r_fq_tail           <= w_fq_tail1;
                end
                2'b10: begin
                    r_fq_mem[r_fq_tail] <= cm_free_phys1;
                    r_fq_tail           <= w_fq_tail1;
                end
                2'b11: begin
                    r_fq_mem[r_fq_tail]  <= cm_free_phys0;
                    r_fq_mem[w_fq_tail1] <= cm_free_phys1;
                    r_fq_tail            <= w_fq_tail2;
                end
                default: ;
            endcase
            if (!w_fq_empty) r_fq_head <= f_fq_inc(r_fq_head);
            r_fq_cnt <= r_fq_cnt + FCW'(w_fq_push_n) - FCW'(!w_fq_empty);
        end
    end

    // Protocol and occupancy checks on the neighbouring stages.
    always @(posedge clk or posedge reset) begin
        if (!reset) begin
            assert (w_req_ok);
            assert ((cm_free_en == 2'b00) || cm_free_ready);
            assert (r_pf_cnt <= C_PF_FULL);
            assert (r_fq_cnt <= C_FQ_FULL);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_preg_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_preg_alloc_ctrl
// Purpose  : Self-checking bench for preg_alloc_ctrl with a lowest-free-first
//            free_list model and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_preg_alloc_ctrl;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    rn_req = '0;
    logic [1:0]    rn_avail;
    logic [PW-1:0] rn_phys0, rn_phys1;
    logic [1:0]    cm_free_en = '0;
    logic [PW-1:0] cm_free_phys0 = '0, cm_free_phys1 = '0;
    logic          cm_free_ready;
    logic          fl_alloc_en;
    logic [PW-1:0] fl_alloc_phys;
    logic          fl_alloc_valid;
    logic          fl_free_en;
    logic [PW-1:0] fl_free_phys;
    logic [2:0]    pf_count;
    logic          fl_exhausted;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    preg_alloc_ctrl dut (
        .clk(clk), .reset(reset),
        .rn_req(rn_req), .rn_avail(rn_avail),
        .rn_phys0(rn_phys0), .rn_phys1(rn_phys1),
        .cm_free_en(cm_free_en), .cm_free_phys0(cm_free_phys0),
        .cm_free_phys1(cm_free_phys1), .cm_free_ready(cm_free_ready),
        .fl_alloc_en(fl_alloc_en), .fl_alloc_phys(fl_alloc_phys),
        .fl_alloc_valid(fl_alloc_valid),
        .fl_free_en(fl_free_en), .fl_free_phys(fl_free_phys),
        .pf_count(pf_count), .fl_exhausted(fl_exhausted)
    );

    // free_list environment: frees apply before alloc, lowest free index wins.
    logic [63:0] fl_mask;
    logic [63:0] w_eff;
    logic        fl_deny = 1'b0;

    always_comb begin
        w_eff = fl_mask;
        if (fl_free_en) w_eff[fl_free_phys] = 1'b1;
        fl_alloc_valid = 1'b0;
        fl_alloc_phys  = '0;
        if (fl_alloc_en && !fl_deny) begin
            for (int i = 63; i >= 0; i--) begin
                if (w_eff[i]) begin
                    fl_alloc_valid = 1'b1;
                    fl_alloc_phys  = 6'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fl_mask <= '1;
        else       fl_mask <= w_eff & ~((fl_alloc_en && fl_alloc_valid) ? (64'd1 << fl_alloc_phys) : 64'd0);
    end

    // Reference model: queues and a three-way mode.
    localparam int M_FILL = 0, M_RUN = 1, M_EXH = 2;
`ifdef PREG_FREE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    int            mstate;
    logic [PW-1:0] pfq[$];
    logic [PW-1:0] fq[$];
    logic [PW-1:0] exp_seq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int m_avail_n();
        if (mstate == M_FILL) return 0;
        return (pfq.size() >= 2) ? 2 : pfq.size();
    endfunction

    function automatic bit m_bypass();
        return BYP && (mstate == M_EXH) && (fq.size() > 0) && (pfq.size() < 4);
    endfunction

    function automatic bit m_alloc_en();
        return (mstate != M_EXH) && (pfq.size() < 4);
    endfunction

    task automatic model_reset();
        mstate = M_FILL;
        pfq.delete();
        fq.delete();
        exp_seq.delete();
    endtask

    task automatic check_model();
        int e0, e1, an;
        bit fe;
        an = m_avail_n();
        fe = (fq.size() > 0) && !m_bypass();
        e0 = 0; e1 = 0;
        if (rn_req[0] && pfq.size() > 0) e0 = pfq[0];
        if (rn_req[1]) e1 = rn_req[0] ? ((pfq.size() > 1) ? int'(pfq[1]) : 0)
                                      : ((pfq.size() > 0) ? int'(pfq[0]) : 0);
        chk("alloc_en",   fl_alloc_en, m_alloc_en());
        chk("pf_count",   pf_count, pfq.size());
        chk("rn_avail",   rn_avail, (an == 2) ? 3 : an);
        chk("rn_phys0",   rn_phys0, e0);
        chk("rn_phys1",   rn_phys1, e1);
        chk("free_en",    fl_free_en, fe);
        chk("free_phys",  fl_free_phys, fe ? int'(fq[0]) : 0);
        chk("free_ready", cm_free_ready, (8 - fq.size()) >= 2);
        chk("exhausted",  fl_exhausted, mstate == M_EXH);
    endtask

    task automatic update_model();
        int n;
        bit ae, byp, fe, ok;
        logic [PW-1:0] bv;
        n   = rn_req[0] + rn_req[1];
        ae  = m_alloc_en();
        byp = m_bypass();
        fe  = (fq.size() > 0) && !byp;
        ok  = fl_alloc_valid;
        bv  = byp ? fq[0] : '0;
        repeat (n) if (pfq.size() > 0) void'(pfq.pop_front());
        if (ae && ok) pfq.push_back(fl_alloc_phys);
        if (byp)      pfq.push_back(bv);
        if (fq.size() > 0) void'(fq.pop_front());
        if (cm_free_en[0]) fq.push_back(cm_free_phys0);
        if (cm_free_en[1]) fq.push_back(cm_free_phys1);
        case (mstate)
            M_FILL: if (ae && !ok) mstate = M_EXH; else if (pfq.size() == 4) mstate = M_RUN;
            M_RUN:  if (ae && !ok) mstate = M_EXH;
            default: if (fe || byp) mstate = M_RUN;
        endcase
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] fen,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        rn_req = req; cm_free_en = fen; cm_free_phys0 = p0; cm_free_phys1 = p1;
        if (fen[0]) exp_seq.push_back(p0);
        if (fen[1]) exp_seq.push_back(p1);
    endtask

    task automatic post();
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [1:0] req, input logic [1:0] fen,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        drive(req, fen, p0, p1);
        @(negedge clk);
        if (fl_free_en) begin
            chk("free_order", fl_free_phys, (exp_seq.size() > 0) ? int'(exp_seq[0]) : -1);
            if (exp_seq.size() > 0) void'(exp_seq.pop_front());
        end
        post();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fl_deny = 1'b0;
        drive(2'b00, 2'b00, '0, '0);
        @(posedge clk);
        #1;
        chk("rst_pf_count", pf_count, 0);
        chk("rst_alloc_en", fl_alloc_en, 0);
        chk("rst_avail",    rn_avail, 0);
        chk("rst_ready",    cm_free_ready, 1);
        chk("rst_free_en",  fl_free_en, 0);
        chk("rst_exh",      fl_exhausted, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [1:0] legal_req(input logic [1:0] r);
        int a;
        a = m_avail_n();
        if (a == 0) return 2'b00;
        if (a == 1 && r == 2'b11) return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        return r;
    endfunction

    typedef struct {
        logic [1:0] req;
        logic       ae;
        int         cnt;
        logic [1:0] av;
        int         p0;
        int         p1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pushes;
        tbl[0]  = '{2'b00, 1'b1, 0, 2'b00, 0, 0};
        tbl[1]  = '{2'b00, 1'b1, 1, 2'b00, 0, 0};
        tbl[2]  = '{2'b00, 1'b1, 2, 2'b00, 0, 0};
        tbl[3]  = '{2'b00, 1'b1, 3, 2'b00, 0, 0};
        tbl[4]  = '{2'b11, 1'b0, 4, 2'b11, 0, 1};
        tbl[5]  = '{2'b00, 1'b1, 2, 2'b11, 0, 0};
        tbl[6]  = '{2'b00, 1'b1, 3, 2'b11, 0, 0};
        tbl[7]  = '{2'b10, 1'b0, 4, 2'b11, 0, 2};
        tbl[8]  = '{2'b01, 1'b1, 3, 2'b11, 3, 0};
        tbl[9]  = '{2'b00, 1'b1, 3, 2'b11, 0, 0};
        tbl[10] = '{2'b11, 1'b0, 4, 2'b11, 4, 5};

        // Fill, double pop, refill, single pops on each lane.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].req, 2'b00, '0, '0);
            @(negedge clk);
            chk($sformatf("tbl%0d_alloc_en", i), fl_alloc_en, tbl[i].ae);
            chk($sformatf("tbl%0d_pf_count", i), pf_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_avail", i),    rn_avail, tbl[i].av);
            chk($sformatf("tbl%0d_phys0", i),    rn_phys0, tbl[i].p0);
            chk($sformatf("tbl%0d_phys1", i),    rn_phys1, tbl[i].p1);
            post();
        end

        // Lane1-only request takes the head; head then advances by one.
        do_reset();
        repeat (4) cycle(2'b00, 2'b00, '0, '0);
        drive(2'b10, 2'b00, '0, '0);
        @(negedge clk);
        chk("lane1_phys1", rn_phys1, 0);
        chk("lane1_phys0", rn_phys0, 0);
        post();
        drive(2'b01, 2'b00, '0, '0);
        @(negedge clk);
        chk("lane1_next_head", rn_phys0, 1);
        post();

        // Exhaust all 64 pregs, then return preg 7.
        do_reset();
        for (int k = 0; k < 300 && mstate != M_EXH; k++)
            cycle((m_avail_n() >= 2) ? 2'b11 : (m_avail_n() == 1) ? 2'b01 : 2'b00, 2'b00, '0, '0);
        chk("reach_exhausted", fl_exhausted, 1);
        cycle(2'b00, 2'b01, 6'd7, '0);
        drive(2'b00, 2'b00, '0, '0);
        @(negedge clk);
        if (BYP) begin
            chk("byp_free_en", fl_free_en, 0);
        end else begin
            chk("ret_free_en",   fl_free_en, 1);
            chk("ret_free_phys", fl_free_phys, 7);
        end
        void'(exp_seq.pop_front());
        post();
        drive(2'b00, 2'b00, '0, '0);
        @(negedge clk);
        chk("ret_exh_left", fl_exhausted, 0);
        if (BYP) begin
            chk("byp_buffered", pf_count, pfq.size());
        end else begin
            chk("ret_alloc_en",    fl_alloc_en, 1);
            chk("ret_alloc_valid", fl_alloc_valid, 1);
            chk("ret_alloc_phys",  fl_alloc_phys, 7);
        end
        post();

        // Back-to-back double frees drain in order; ready drops near full.
        do_reset();
        repeat (4) cycle(2'b00, 2'b00, '0, '0);
        pushes = 0;
        for (int k = 0; k < 20 && (8 - fq.size()) >= 2; k++) begin
            cycle(2'b00, 2'b11, 6'd9, 6'd12);
            pushes++;
        end
        chk("fq_ready_drop", cm_free_ready, 0);
        chk("fq_pushes_before_drop", pushes, 6);
        repeat (10) cycle(2'b00, 2'b00, '0, '0);
        chk("fq_all_drained", exp_seq.size(), 0);

        // Asynchronous reset mid-refill.
        do_reset();
        repeat (4) cycle(2'b00, 2'b00, '0, '0);
        cycle(2'b01, 2'b11, 6'd20, 6'd21);
        chk("pre_rst_pf_count", pf_count, 3);
        drive(2'b00, 2'b00, '0, '0);
        #2 reset = 1'b1;
        #1;
        chk("async_pf_count",  pf_count, 0);
        chk("async_alloc_en",  fl_alloc_en, 0);
        chk("async_avail",     rn_avail, 0);
        chk("async_free_en",   fl_free_en, 0);
        chk("async_free_phys", fl_free_phys, 0);
        chk("async_ready",     cm_free_ready, 1);
        chk("async_exh",       fl_exhausted, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 2'b00, '0, '0);
            @(negedge clk);
            chk($sformatf("refill%0d_phys", i), fl_alloc_phys, i);
            post();
        end

        // Randomised traffic, including free_list refusals.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [1:0] fen;
            fl_deny = ($urandom_range(0, 7) == 0);
            fen = ((8 - fq.size()) >= 2 && $urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cycle(legal_req(2'($urandom_range(0, 3))), fen,
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end
        fl_deny = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
